bch_syndrome: RTL and testbench

- Decoder front end; sits directly downstream of bch_encode, across the channel.
- Consumes a received codeword stream BITS bits/cycle, using the same framing and start/ce protocol as bch_encode output.
- Accumulates the odd syndromes S1, S3 … S(2T-1) over GF(2^M) and presents them with an error flag to the error-locator stage.
- Holds the result until it is accepted.

---
 rtl/bch_syndrome_pkg.sv | 72 +++++++
 rtl/bch_syndrome_term.sv | 30 +++
 rtl/bch_syndrome.sv | 117 +++++++++++
 tb/tb_bch_syndrome.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bch_syndrome_pkg.sv
// Shared GF(2^M) helpers and state encoding for the BCH syndrome front end.
package bch_syndrome_pkg;

    localparam int unsigned GF_MAX_W = 16;

    typedef logic [GF_MAX_W-1:0] gf_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_e;

    // Primitive polynomial (including the x^m term) used to build GF(2^m).
    function automatic logic [GF_MAX_W:0] prim_poly(input int unsigned m);
        case (m)
            2:       return 17'h00007;
            3:       return 17'h0000B;
            4:       return 17'h00013;
            5:       return 17'h00025;
            6:       return 17'h00043;
            7:       return 17'h00089;
            8:       return 17'h0011D;
            9:       return 17'h00211;
            10:      return 17'h00409;
            11:      return 17'h00805;
            12:      return 17'h01053;
            13:      return 17'h0201B;
            14:      return 17'h04443;
            15:      return 17'h08003;
            16:      return 17'h1100B;
            default: return 17'h00000;
        endcase
    endfunction

    function automatic gf_t finite_mult(input int unsigned m, input gf_t a, input gf_t b);
        logic [GF_MAX_W:0] r;
        logic [GF_MAX_W:0] poly;
        poly = prim_poly(m);
        r    = '0;
        for (int i = GF_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(m)) begin
                r = {r[GF_MAX_W-1:0], 1'b0};
                if (r[5'(m)]) r = r ^ poly;
                if (b[4'(i)]) r = r ^ {1'b0, a};
            end
        end
        return r[GF_MAX_W-1:0];
    endfunction

    // alpha^e, with the exponent reduced modulo the field order.
    function automatic gf_t lpow(input int unsigned m, input int unsigned e);
        logic [GF_MAX_W:0] r;
        logic [GF_MAX_W:0] poly;
        int unsigned       ord;
        poly = prim_poly(m);
        ord  = (32'd1 << m) - 32'd1;
        r    = 17'd1;
        for (int unsigned i = 0; i < (e % ord); i++) begin
            r = {r[GF_MAX_W-1:0], 1'b0};
            if (r[5'(m)]) r = r ^ poly;
        end
        return r[GF_MAX_W-1:0];
    endfunction

    // Weight of bit k of a word in the Horner step for syndrome S_j.
    function automatic gf_t syndrome_power(input int unsigned m, input int unsigned j,
                                           input int unsigned k);
        return lpow(m, j * k);
    endfunction

endpackage

// File: rtl/bch_syndrome_term.sv
// One combinational Horner step for S_J: acc*alpha^(J*BITS) xor sum word[k]*alpha^(J*k).
module bch_syndrome_term
    import bch_syndrome_pkg::*;
#(
    parameter int unsigned M    = 4,
    parameter int unsigned J    = 1,
    parameter int unsigned BITS = 1
) (
    input  logic [M-1:0]    acc,
    input  logic [BITS-1:0] word,
    output logic [M-1:0]    nxt_c
);

    localparam gf_t SHIFT_POW = syndrome_power(M, J, BITS);

    logic [M-1:0] tap_c [BITS];

    for (genvar k = 0; k < BITS; k++) begin : g_tap
        localparam gf_t TAP_POW = syndrome_power(M, J, k);
        assign tap_c[k] = word[k] ? TAP_POW[M-1:0] : '0;
    end

    always_comb begin
        nxt_c = M'(finite_mult(M, gf_t'(acc), SHIFT_POW));
        for (int k = 0; k < BITS; k++) begin
            nxt_c = nxt_c ^ tap_c[k];
        end
    end

endmodule

// File: rtl/bch_syndrome.sv
// Odd-syndrome accumulator for a received BCH codeword stream; result held until acked.
module bch_syndrome
    import bch_syndrome_pkg::*;
#(
    parameter int unsigned M         = 4,
    parameter int unsigned T         = 2,
    parameter int unsigned DATA_BITS = 7,
    parameter int unsigned BITS      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              ce,
    input  logic [BITS-1:0]   data_in,
    output logic              ready,
    output logic              syn_valid,
    input  logic              syn_ack,
    output logic [T*M-1:0]    syndromes,
    output logic              error
);

    localparam int unsigned ECC_BITS    = M * T;
    localparam int unsigned DATA_CYCLES = (DATA_BITS + BITS - 1) / BITS;
    localparam int unsigned ECC_CYCLES  = (ECC_BITS + BITS - 1) / BITS;
    localparam int unsigned CODE_CYCLES = DATA_CYCLES + ECC_CYCLES;
    localparam int unsigned PAD         = CODE_CYCLES * BITS - DATA_BITS - ECC_BITS;
    localparam int unsigned CNT_W       = (CODE_CYCLES < 2) ? 1 : $clog2(CODE_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_CYCLES - 1);
    localparam bit ONE_WORD = (CODE_CYCLES == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [T*M-1:0]   syn_q, syn_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;

    logic             load_c;
    logic [T*M-1:0]   acc_in_c;
    logic [T*M-1:0]   syn_next_c;
    logic [BITS-1:0]  word_c;
    int unsigned      word_idx_c;

    assign load_c   = ce && start && (state_q != ST_DONE);
    assign acc_in_c = load_c ? '0 : syn_q;

    // Leading pad bits of the stream carry no code weight and are forced to zero.
    always_comb begin
        word_c     = '0;
        word_idx_c = load_c ? 32'd0 : 32'(cnt_q);
        for (int k = 0; k < BITS; k++) begin
            word_c[k] = data_in[k] & ((word_idx_c * BITS + (BITS - 1 - k)) >= PAD);
        end
    end

    for (genvar i = 0; i < T; i++) begin : g_term
        bch_syndrome_term #(
            .M    (M),
            .J    (2 * i + 1),
            .BITS (BITS)
        ) u_term (
            .acc   (acc_in_c[i*M +: M]),
            .word  (word_c),
            .nxt_c (syn_next_c[i*M +: M])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        syn_d   = syn_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (load_c) begin
                    syn_d   = syn_next_c;
                    cnt_d   = CNT_W'(1);
                    state_d = ONE_WORD ? ST_DONE : ST_ACCUM;
                end else if (ce && (state_q == ST_ACCUM)) begin
                    syn_d = syn_next_c;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (syn_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d != ST_DONE);
        valid_d = (state_d == ST_DONE);
        error_d = |syn_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            syn_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            syn_q   <= syn_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    assign ready     = ready_q;
    assign syn_valid = valid_q;
    assign syndromes = syn_q;
    assign error     = error_q;

endmodule

// File: tb/tb_bch_syndrome.sv
// Bench for bch_syndrome on the (15,7) t=2 code, one instance at 1 bit/cycle and one at 4.
module tb_bch_syndrome;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    logic       start1 = 1'b0, ce1 = 1'b0, ack1 = 1'b0;
    logic [0:0] din1   = '0;
    logic       rdy1, val1, err1;
    logic [7:0] syn1;

    logic       start4 = 1'b0, ce4 = 1'b0, ack4 = 1'b0;
    logic [3:0] din4   = '0;
    logic       rdy4, val4, err4;
    logic [7:0] syn4;

    bch_syndrome #(.M(4), .T(2), .DATA_BITS(7), .BITS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .ce(ce1), .data_in(din1),
        .ready(rdy1), .syn_valid(val1), .syn_ack(ack1), .syndromes(syn1), .error(err1)
    );

    bch_syndrome #(.M(4), .T(2), .DATA_BITS(7), .BITS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .start(start4), .ce(ce4), .data_in(din4),
        .ready(rdy4), .syn_valid(val4), .syn_ack(ack4), .syndromes(syn4), .error(err4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] alpha_exp [15];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: evaluate r(alpha^j) directly from the bit positions of the codeword.
    function automatic logic [7:0] model_syn(input logic [14:0] c);
        logic [3:0] s1, s3;
        s1 = '0;
        s3 = '0;
        for (int d = 0; d < 15; d++) begin
            if (c[d]) begin
                s1 = s1 ^ alpha_exp[d];
                s3 = s3 ^ alpha_exp[(3 * d) % 15];
            end
        end
        return {s3, s1};
    endfunction

    // Systematic encoder: c(x) = d(x)x^8 + (d(x)x^8 mod g(x)), g = x^8+x^7+x^6+x^4+1.
    function automatic logic [14:0] encode(input logic [6:0] d);
        logic [14:0] r;
        r = {d, 8'h00};
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        end
        return {d, r[7:0]};
    endfunction

    function automatic logic [3:0] word_of(input bit sel, input logic [15:0] s, input int w);
        if (sel) return s[15 - 4 * w -: 4];
        return {3'b000, s[14 - w]};
    endfunction

    function automatic logic rd_rdy(input bit sel); return sel ? rdy4 : rdy1; endfunction
    function automatic logic rd_val(input bit sel); return sel ? val4 : val1; endfunction
    function automatic logic rd_err(input bit sel); return sel ? err4 : err1; endfunction
    function automatic logic [7:0] rd_syn(input bit sel); return sel ? syn4 : syn1; endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit sel, input logic s, input logic e, input logic [3:0] d);
        if (sel) begin
            start4 = s; ce4 = e; din4 = d;
        end else begin
            start1 = s; ce1 = e; din1 = d[0];
        end
    endtask

    task automatic set_ack(input bit sel, input logic a);
        if (sel) ack4 = a; else ack1 = a;
    endtask

    task automatic wait_ready(input bit sel, input string tag);
        for (int i = 0; i < 6 && !rd_rdy(sel); i++) tick;
        check_eq({tag, "/ready_timeout"}, 32'(rd_rdy(sel)), 32'd1);
    endtask

    task automatic do_ack(input bit sel, input string tag);
        set_ack(sel, 1'b1);
        tick;
        set_ack(sel, 1'b0);
        check_eq({tag, "/val_after_ack"}, 32'(rd_val(sel)), 32'd0);
        check_eq({tag, "/rdy_after_ack"}, 32'(rd_rdy(sel)), 32'd1);
    endtask

    // Feed one codeword with optional random ce-low gaps; pad is the leading stream bit.
    task automatic run_code(input bit sel, input logic [14:0] c, input int gap_max,
                            input logic pad, input string tag);
        int          nw;
        int          g;
        logic [15:0] s;
        logic [7:0]  exp_syn;
        nw      = sel ? 4 : 15;
        s       = {pad, c};
        exp_syn = model_syn(c);
        for (int w = 0; w < nw; w++) begin
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            for (int i = 0; i < g; i++) begin
                put(sel, 1'($urandom), 1'b0, 4'($urandom));
                tick;
            end
            check_eq({tag, "/rdy"}, 32'(rd_rdy(sel)), 32'd1);
            put(sel, w == 0, 1'b1, word_of(sel, s, w));
            tick;
            put(sel, 1'b0, 1'b0, 4'h0);
            if (w < nw - 1) check_eq({tag, "/val_early"}, 32'(rd_val(sel)), 32'd0);
        end
        check_eq({tag, "/val"}, 32'(rd_val(sel)), 32'd1);
        check_eq({tag, "/syn"}, 32'(rd_syn(sel)), 32'(exp_syn));
        check_eq({tag, "/err"}, 32'(rd_err(sel)), 32'(|exp_syn));
    endtask

    task automatic send_partial(input bit sel, input logic [14:0] c, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            put(sel, w == 0, 1'b1, word_of(sel, {1'b0, c}, w));
            tick;
        end
        put(sel, 1'b0, 1'b0, 4'h0);
    endtask

    function automatic logic [14:0] rand_code();
        logic [14:0] c;
        c = encode(7'($urandom));
        case ($urandom_range(2, 0))
            0:       c = c ^ (15'd1 << $urandom_range(14, 0));
            1:       c = 15'($urandom);
            default: c = c;
        endcase
        return c;
    endfunction

    initial begin
        logic [3:0]  e;
        logic [14:0] ca, cb;
        logic [7:0]  held;
        e = 4'h1;
        for (int i = 0; i < 15; i++) begin
            alpha_exp[i] = e;
            e = {e[2:0], 1'b0} ^ (e[3] ? 4'h3 : 4'h0);
        end

        #1 reset_n = 1'b0;
        #2;
        check_eq("rst/rdy1", 32'(rdy1), 32'd0);
        check_eq("rst/val1", 32'(val1), 32'd0);
        check_eq("rst/syn4", 32'(syn4), 32'd0);
        check_eq("rst/err4", 32'(err4), 32'd0);
        #19 reset_n = 1'b1;
        tick;
        wait_ready(1'b0, "boot1");
        wait_ready(1'b1, "boot4");

        run_code(1'b0, 15'h0000, 0, 1'b0, "zero1");
        do_ack(1'b0, "zero1");

        run_code(1'b0, 15'h4000, 0, 1'b0, "deg14");
        check_eq("deg14/const", 32'(syn1), 32'h0000_00F9);
        do_ack(1'b0, "deg14");

        run_code(1'b1, encode(7'h5A), 0, 1'b0, "enc5a");
        check_eq("enc5a/const", 32'(syn4), 32'd0);
        do_ack(1'b1, "enc5a");

        run_code(1'b1, encode(7'h5A) ^ 15'h0001, 0, 1'b0, "enc5a_flip");
        check_eq("enc5a_flip/const", 32'(syn4), 32'h0000_0011);
        held = syn4;
        for (int i = 0; i < 10; i++) begin
            put(1'b1, 1'($urandom), 1'($urandom), 4'($urandom));
            tick;
            check_eq("hold/syn", 32'(syn4), 32'(held));
            check_eq("hold/rdy", 32'(rdy4), 32'd0);
            check_eq("hold/val", 32'(val4), 32'd1);
        end
        put(1'b1, 1'b0, 1'b0, 4'h0);
        do_ack(1'b1, "hold");
        run_code(1'b1, rand_code(), 0, 1'b0, "post_ack");
        do_ack(1'b1, "post_ack");

        ca = rand_code();
        cb = rand_code();
        send_partial(1'b1, ca, 2);
        run_code(1'b1, cb, 0, 1'b0, "restart");
        do_ack(1'b1, "restart");

        send_partial(1'b1, rand_code(), 2);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid/rdy", 32'(rdy4), 32'd0);
        check_eq("rst_mid/val", 32'(val4), 32'd0);
        check_eq("rst_mid/syn", 32'(syn4), 32'd0);
        check_eq("rst_mid/err", 32'(err4), 32'd0);
        #3 reset_n = 1'b1;
        wait_ready(1'b1, "rst_mid");
        run_code(1'b1, rand_code(), 0, 1'b0, "after_rst");
        do_ack(1'b1, "after_rst");
        wait_ready(1'b0, "rst_mid1");

        for (int n = 0; n < 16; n++) begin
            run_code(1'b1, rand_code(), 3, 1'($urandom), "rand4");
            for (int i = 0; i < int'($urandom_range(3, 0)); i++) tick;
            do_ack(1'b1, "rand4");
        end
        for (int n = 0; n < 8; n++) begin
            run_code(1'b0, rand_code(), 2, 1'b0, "rand1");
            do_ack(1'b0, "rand1");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
